// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and constants for the UART transmit peripheral.
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;
  localparam int ST_BUSY = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL = 2;
  localparam int ST_OVF = 3;
  localparam int ST_COUNT = 8;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = FRAME_BITS - 2;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; a push while full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_do_push, w_do_pop;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd];
  assign w_do_pop = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_do_push);
      r_rd <= r_rd + AW'(w_do_pop);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-mapped 8N1 UART transmitter with TX FIFO, baud divisor and status/irq.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        we,
  input  logic        reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] status,
  output logic        txd,
  output logic        busy,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state, w_state_n;
  logic [DIV_W-1:0] r_div, r_div_act, w_div_act_n, r_timer, w_timer_n;
  logic [2:0] r_bit, w_bit_n;
  logic [7:0] r_shift, w_shift_n, w_fifo_data;
  logic r_ovf, w_push, w_pop, w_full, w_empty, w_tick, w_ctrl_we, w_unused;
  logic [CW-1:0] w_count;
  assign w_push = we && reg_sel == REG_TXDATA;
  assign w_ctrl_we = we && reg_sel == REG_CTRL;
  assign w_tick = r_timer == '0;
  assign busy = r_state != S_IDLE;
  assign irq = w_empty && !busy;
  assign txd = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_shift[0] : 1'b1;
  assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
  assign w_unused = &{1'b0, wdata[30:DIV_W]};
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk), .rst_n(RSTN), .i_push(w_push), .i_pop(w_pop), .i_data(wdata[7:0]),
    .o_data(w_fifo_data), .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      r_div <= DIV_W'(DEFAULT_DIV);
      r_ovf <= 1'b0;
    end else begin
      if (w_ctrl_we) r_div <= wdata[DIV_W-1:0] < DIV_W'(2) ? DIV_W'(2) : wdata[DIV_W-1:0];
      r_ovf <= (w_ctrl_we && wdata[31]) ? 1'b0 : r_ovf | (w_push && w_full && !w_pop);
    end
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_div_act <= DIV_W'(DEFAULT_DIV);
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_bit <= w_bit_n;
      r_shift <= w_shift_n;
      r_div_act <= w_div_act_n;
    end
  // Timer reloads from the divisor latched at frame start, so CTRL writes never disturb a frame.
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_state == S_IDLE ? r_timer : w_tick ? r_div_act - DIV_W'(1) : r_timer - DIV_W'(1);
    w_bit_n = r_bit;
    w_shift_n = r_shift;
    w_div_act_n = r_div_act;
    case (r_state)
      S_IDLE: ;
      S_START: if (w_tick) begin
        w_state_n = S_DATA;
        w_bit_n = '0;
      end
      S_DATA: if (w_tick) begin
        w_shift_n = r_shift >> 1;
        w_bit_n = r_bit + 3'd1;
        if (r_bit == 3'(DATA_BITS - 1)) w_state_n = S_STOP;
      end
      S_STOP: if (w_tick) w_state_n = S_IDLE;
    endcase
    if (w_pop) begin
      w_state_n = S_START;
      w_shift_n = w_fifo_data;
      w_div_act_n = r_div;
      w_timer_n = r_div - DIV_W'(1);
    end
  end
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_EMPTY] = w_empty;
    status[ST_FULL] = w_full;
    status[ST_OVF] = r_ovf;
    status[ST_COUNT +: CW] = w_count;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, queueing, overflow, divisor change and async reset.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic RSTN, we, reg_sel, txd, busy, irq;
  logic [31:0] wdata, status;
  int checks = 0;
  int failures = 0;
  uart_tx_fifo dut (
    .clk(clk), .RSTN(RSTN), .we(we), .reg_sel(reg_sel), .wdata(wdata),
    .status(status), .txd(txd), .busy(busy), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic sel, input logic [31:0] d);
    we = 1'b1;
    reg_sel = sel;
    wdata = d;
    step();
    we = 1'b0;
  endtask
  // Walks one frame from cycle 'from' (0 = first START cycle), ending on the next frame's cycle 0.
  task automatic chk_frame(input logic [7:0] b, input int div, input int from);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = from; k < 10 * div; k++) begin
      chk("frame_txd", 32'(txd), 32'(f[k / div]));
      chk("frame_busy", 32'(busy), 1);
      chk("frame_irq", 32'(irq), 0);
      step();
    end
  endtask
  initial begin
    RSTN = 1'b0;
    we = 1'b0;
    reg_sel = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 1);
    chk("rst_status", status, 32'h2);
    RSTN = 1'b1;
    step();
    chk("idle_status", status, 32'h2);
    wr(1'b1, 32'd4);
    wr(1'b0, 32'h55);
    chk("prepop_txd", 32'(txd), 1);
    chk("prepop_status", status, 32'h100);
    step();
    chk("start_status", status, 32'h3);
    chk_frame(8'h55, 4, 0);
    chk("f55_busy_end", 32'(busy), 0);
    chk("f55_irq_end", 32'(irq), 1);
    wr(1'b0, 32'h01);
    wr(1'b0, 32'h02);
    wr(1'b0, 32'h03);
    chk("q_count2", 32'(status[12:8]), 2);
    chk_frame(8'h01, 4, 1);
    chk("q_count1", 32'(status[12:8]), 1);
    chk_frame(8'h02, 4, 0);
    chk("q_count0", 32'(status[12:8]), 0);
    chk_frame(8'h03, 4, 0);
    chk("q_busy_end", 32'(busy), 0);
    chk("q_irq_end", 32'(irq), 1);
    wr(1'b1, 32'd100);
    for (int i = 0; i < 18; i++) wr(1'b0, 32'(i));
    chk("ovf_status", status, 32'h100D);
    wr(1'b1, 32'h80000064);
    chk("ovf_clear_status", status, 32'h1005);
    repeat (982) step();
    chk("d100_stop_txd", 32'(txd), 1);
    step();
    chk("d100_next_start_txd", 32'(txd), 0);
    chk("d100_next_status", status, 32'h0F01);
    RSTN = 1'b0;
    step();
    chk("flush_status", status, 32'h2);
    RSTN = 1'b1;
    step();
    wr(1'b1, 32'd4);
    wr(1'b0, 32'hA5);
    wr(1'b0, 32'h3C);
    repeat (8) step();
    wr(1'b1, 32'd8);
    chk_frame(8'hA5, 4, 9);
    chk_frame(8'h3C, 8, 0);
    chk("div8_busy_end", 32'(busy), 0);
    chk("div8_irq_end", 32'(irq), 1);
    wr(1'b1, 32'd4);
    wr(1'b0, 32'hF0);
    wr(1'b0, 32'h0F);
    repeat (5) step();
    chk("pre_arst_txd", 32'(txd), 0);
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_txd", 32'(txd), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_status", status, 32'h2);
    step();
    RSTN = 1'b1;
    step();
    chk("post_arst_status", status, 32'h2);
    repeat (5) step();
    chk("post_arst_idle_txd", 32'(txd), 1);
    chk("post_arst_idle_status", status, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
